// File: rtl/intv_cart_loader.sv
`default_nettype none
// ============================================================================
// Module   : intv_cart_loader
// Brief    : Packs the HPS ioctl byte stream into big-endian 16-bit cartridge
//            words, buffers them and writes them to cart ROM memory.
//            Optional checksum/rom_empty outputs: INTV_LOADER_CHECKSUM_EN
// Revision : 1.0 - initial release
// ============================================================================
module intv_cart_loader #(
    parameter int FILE_INDEX = 0,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              loading,
    output logic              load_done,
`ifdef INTV_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
    output logic              rom_empty,
`endif
    output logic [16:0]       rom_words
);

    localparam int             PTR_W       = $clog2(DEPTH);
    localparam int             ENT_W       = ADDR_W + 16;
    localparam logic [5:0]     C_FILE_IDX  = 6'(FILE_INDEX);
    localparam logic [PTR_W:0] C_FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] C_WAIT_LVL  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [16:0]    C_WORDS_MAX = 17'h1FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state_q,      w_state_d;
    logic              r_sel_q;
    logic              r_start_pend_q, w_start_pend_d;
    logic              r_pend_q,       w_pend_d;
    logic [ADDR_W-1:0] r_pend_addr_q,  w_pend_addr_d;
    logic [7:0]        r_hi_q,         w_hi_d;
    logic              r_overflow_q,   w_overflow_d;
    logic [PTR_W-1:0]  r_wr_ptr_q,     w_wr_ptr_d;
    logic [PTR_W-1:0]  r_rd_ptr_q,     w_rd_ptr_d;
    logic [PTR_W:0]    r_count_q,      w_count_d;
    logic              r_mem_we_q,     w_mem_we_d;
    logic [ADDR_W-1:0] r_mem_addr_q,   w_mem_addr_d;
    logic [15:0]       r_mem_data_q,   w_mem_data_d;
    logic              r_wait_q,       w_wait_d;
    logic [16:0]       r_rom_words_q,  w_rom_words_d;
    logic [ENT_W-1:0]  r_fifo_q [DEPTH];

    logic              w_sel, w_full, w_empty, w_push, w_pop, w_xfer, w_start;
    logic [ENT_W-1:0]  w_push_data;
    logic [ADDR_W-1:0] w_byte_addr;
    logic              w_unused;

    assign w_unused = ^{ioctl_index[7:6], ioctl_addr[24:ADDR_W+1]};

    always_comb begin
        w_sel       = ioctl_download && (ioctl_index[5:0] == C_FILE_IDX);
        w_full      = (r_count_q == C_FULL);
        w_empty     = (r_count_q == '0);
        w_xfer      = r_mem_we_q && mem_ready;
        w_pop       = !w_empty && (!r_mem_we_q || mem_ready);
        w_byte_addr = ioctl_addr[ADDR_W:1];
        // A rising edge seen during DONE is remembered and taken here.
        w_start     = (r_state_q == S_IDLE) && ((w_sel && !r_sel_q) || r_start_pend_q);
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_start_pend_d = r_start_pend_q;
        w_pend_d       = r_pend_q;
        w_pend_addr_d  = r_pend_addr_q;
        w_hi_d         = r_hi_q;
        w_overflow_d   = r_overflow_q;
        w_push         = 1'b0;
        w_push_data    = '0;
        unique case (r_state_q)
            S_IDLE: begin
                if (w_start) begin
                    w_state_d      = S_LOAD;
                    w_start_pend_d = 1'b0;
                    w_overflow_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (!w_sel) begin
                    w_state_d = S_FLUSH;
                end else if (ioctl_wr) begin
                    if (w_full) begin
                        w_overflow_d = 1'b1;
                    end else if (!ioctl_addr[0]) begin
                        w_push        = r_pend_q;
                        w_push_data   = {r_pend_addr_q, r_hi_q, 8'h00};
                        w_hi_d        = ioctl_dout;
                        w_pend_addr_d = w_byte_addr;
                        w_pend_d      = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        if (r_pend_q && (r_pend_addr_q == w_byte_addr)) begin
                            w_push_data = {w_byte_addr, r_hi_q, ioctl_dout};
                        end else begin
                            w_push_data = {w_byte_addr, 8'h00, ioctl_dout};
                        end
                        w_pend_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (r_pend_q) begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_data = {r_pend_addr_q, r_hi_q, 8'h00};
                        w_pend_d    = 1'b0;
                    end
                end else if (w_empty && !r_mem_we_q) begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                if (w_sel && !r_sel_q) begin
                    w_start_pend_d = 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_data_d  = r_mem_data_q;
        w_rom_words_d = r_rom_words_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + (PTR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - (PTR_W+1)'(1);
        end
        // The output register is refilled whenever it is empty or being accepted.
        if (w_pop) begin
            w_mem_we_d                   = 1'b1;
            {w_mem_addr_d, w_mem_data_d} = r_fifo_q[r_rd_ptr_q];
        end else if (w_xfer) begin
            w_mem_we_d = 1'b0;
        end
        if (w_start) begin
            w_rom_words_d = '0;
        end else if (w_xfer && (r_rom_words_q != C_WORDS_MAX)) begin
            w_rom_words_d = r_rom_words_q + 17'd1;
        end
        w_wait_d = ((w_state_d == S_LOAD) || (w_state_d == S_FLUSH)) &&
                   (w_count_d >= C_WAIT_LVL);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state_q      <= S_IDLE;
            r_sel_q        <= 1'b0;
            r_start_pend_q <= 1'b0;
            r_pend_q       <= 1'b0;
            r_pend_addr_q  <= '0;
            r_hi_q         <= '0;
            r_overflow_q   <= 1'b0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
            r_mem_we_q     <= 1'b0;
            r_mem_addr_q   <= '0;
            r_mem_data_q   <= '0;
            r_wait_q       <= 1'b0;
            r_rom_words_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_sel_q        <= w_sel;
            r_start_pend_q <= w_start_pend_d;
            r_pend_q       <= w_pend_d;
            r_pend_addr_q  <= w_pend_addr_d;
            r_hi_q         <= w_hi_d;
            r_overflow_q   <= w_overflow_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
            r_mem_we_q     <= w_mem_we_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_data_q   <= w_mem_data_d;
            r_wait_q       <= w_wait_d;
            r_rom_words_q  <= w_rom_words_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_q[r_wr_ptr_q] <= w_push_data;
        end
    end

`ifdef INTV_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum_q,  w_checksum_d;
    logic        r_rom_empty_q, w_rom_empty_d;

    always_comb begin
        w_checksum_d  = r_checksum_q;
        w_rom_empty_d = r_rom_empty_q;
        if (w_start) begin
            w_checksum_d  = '0;
            w_rom_empty_d = 1'b0;
        end else begin
            if (w_xfer) begin
                w_checksum_d = r_checksum_q + r_mem_data_q;
            end
            if ((r_state_q == S_FLUSH) && (w_state_d == S_DONE)) begin
                w_rom_empty_d = (r_rom_words_q == '0);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_checksum_q  <= '0;
            r_rom_empty_q <= 1'b0;
        end else begin
            r_checksum_q  <= w_checksum_d;
            r_rom_empty_q <= w_rom_empty_d;
        end
    end

    assign checksum  = r_checksum_q;
    assign rom_empty = r_rom_empty_q;
`endif

    assign ioctl_wait = r_wait_q;
    assign mem_addr   = r_mem_addr_q;
    assign mem_data   = r_mem_data_q;
    assign mem_we     = r_mem_we_q;
    assign loading    = (r_state_q == S_LOAD) || (r_state_q == S_FLUSH);
    assign load_done  = (r_state_q == S_DONE);
    assign rom_words  = r_rom_words_q;

endmodule
`default_nettype wire

// File: tb/tb_intv_cart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_intv_cart_loader
// Brief    : Self-checking bench for intv_cart_loader; a byte-stream model
//            predicts the words written to cart memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intv_cart_loader;

    localparam int DEPTH = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        loading;
    logic        load_done;
    logic [16:0] rom_words;
`ifdef INTV_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
    logic        rom_empty;
    logic [15:0] cs_at_done;
    logic        re_at_done;
`endif

    intv_cart_loader #(.FILE_INDEX(0), .DEPTH(DEPTH), .ADDR_W(16)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_ready      (mem_ready),
        .loading        (loading),
        .load_done      (load_done),
`ifdef INTV_LOADER_CHECKSUM_EN
        .checksum       (checksum),
        .rom_empty      (rom_empty),
`endif
        .rom_words      (rom_words)
    );

    always #5 clk_sys = ~clk_sys;

    int          total = 0;
    int          bad   = 0;
    int          we_cnt = 0;
    int          ready_mode = 1;
    logic [7:0]  fbytes[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [15:0] exp_sum;
    logic [31:0] prev_word = '0;
    bit          prev_stall = 1'b0;
    bit          loading_at_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-side: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'b0;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk_sys) begin
        if (prev_stall) begin
            check("hold_we", mem_we, 1);
            check("hold_word", {mem_addr, mem_data}, prev_word);
        end
        prev_stall = reset_n && mem_we && !mem_ready;
        prev_word  = {mem_addr, mem_data};
        if (reset_n && mem_we && mem_ready) got_q.push_back({mem_addr, mem_data});
        if (mem_we) we_cnt++;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_raw(input int a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        int guard = 0;
        while (ioctl_wait && guard < 500) begin
            tick();
            guard++;
        end
        check("wait_released", ioctl_wait, 0);
        send_raw(a, d);
    endtask

    task automatic set_bytes(input logic [63:0] v, input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic rand_bytes(input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom));
    endtask

    // Big-endian pairing: word k = {byte 2k, byte 2k+1}, missing low byte is 00.
    function automatic void build_exp();
        logic [7:0] lo;
        exp_q.delete();
        exp_sum = '0;
        for (int i = 0; i < fbytes.size(); i += 2) begin
            lo = (i + 1 < fbytes.size()) ? fbytes[i+1] : 8'h00;
            exp_q.push_back({16'(i / 2), fbytes[i], lo});
            exp_sum = exp_sum + {fbytes[i], lo};
        end
    endfunction

    task automatic begin_load();
        got_q.delete();
        build_exp();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        check("loading_start", loading, 1);
    endtask

    task automatic end_load();
        int pulses = 0;
        bit seen   = 1'b0;
        ioctl_download = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            tick();
            if (load_done) begin
                seen = 1'b1;
                pulses++;
                loading_at_done = loading;
`ifdef INTV_LOADER_CHECKSUM_EN
                cs_at_done = checksum;
                re_at_done = rom_empty;
`endif
            end
        end
        check("done_seen", seen, 1);
        check("loading_at_done", loading_at_done, 0);
        repeat (3) begin
            tick();
            if (load_done) pulses++;
        end
        check("done_pulses", pulses, 1);
        check("loading_after", loading, 0);
    endtask

    task automatic compare_load();
        check("nwords", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check($sformatf("word%0d", k), got_q[k], exp_q[k]);
        end
        check("rom_words", rom_words, exp_q.size());
        check("no_overflow", dut.r_overflow_q, 0);
`ifdef INTV_LOADER_CHECKSUM_EN
        check("checksum", cs_at_done, exp_sum);
        check("rom_empty", re_at_done, exp_q.size() == 0);
`endif
    endtask

    task automatic run_load(input int gap_max);
        begin_load();
        for (int i = 0; i < fbytes.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_byte(i, fbytes[i]);
        end
        end_load();
        compare_load();
    endtask

    initial begin
        int i;
        int we_before;
        int pulses;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();
        check("rst_mem_we", mem_we, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_loading", loading, 0);
        check("rst_done", load_done, 0);
        check("rst_words", rom_words, 0);
        check("rst_word", {mem_addr, mem_data}, 0);
        reset_n = 1'b1;
        tick();

        // 12 34 56 78 with memory always ready, plus first-word latency.
        ready_mode = 0;
        set_bytes(64'h12345678, 4);
        begin_load();
        send_byte(0, fbytes[0]);
        send_byte(1, fbytes[1]);
        check("lat_cyc1_we", mem_we, 0);
        tick();
        check("lat_cyc2_we", mem_we, 1);
        check("lat_cyc2_word", {mem_addr, mem_data}, 32'h0000_1234);
        send_byte(2, fbytes[2]);
        send_byte(3, fbytes[3]);
        end_load();
        compare_load();

        // Odd-length file: last word flushed with a zero low byte.
        set_bytes(64'hABCDEF, 3);
        run_load(0);
        check("odd_tail", got_q.size() > 1 ? got_q[1] : 32'h0, 32'h0001_EF00);

        // Empty file.
        fbytes.delete();
        run_load(0);

`ifdef INTV_LOADER_CHECKSUM_EN
        set_bytes(64'hFFFF0002, 4);
        run_load(1);
        check("checksum_wrap", cs_at_done, 16'h0001);
`endif

        // Foreign file index is ignored entirely.
        got_q.delete();
        we_before      = we_cnt;
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            send_byte(k, 8'($urandom));
            check("idx_loading", loading, 0);
        end
        ioctl_download = 1'b0;
        repeat (3) tick();
        check("idx_no_we", we_cnt - we_before, 0);
        check("idx_no_xfer", got_q.size(), 0);
        ioctl_index = 8'd0;

        // Back-pressure: wait must rise at DEPTH-2 and absorb one extra byte.
        ready_mode = 1;
        rand_bytes(24);
        begin_load();
        i = 0;
        while (i < fbytes.size() && !ioctl_wait) begin
            send_byte(i, fbytes[i]);
            i++;
        end
        check("bp_wait_high", ioctl_wait, 1);
        check("bp_fifo_lvl", dut.r_count_q, DEPTH - 2);
        send_raw(i, fbytes[i]);
        i++;
        check("bp_no_ovf", dut.r_overflow_q, 0);
        repeat (4) tick();
        check("bp_no_xfer", got_q.size(), 0);
        ready_mode = 2;
        while (i < fbytes.size()) begin
            send_byte(i, fbytes[i]);
            i++;
        end
        end_load();
        compare_load();

        for (int r = 0; r < 4; r++) begin
            ready_mode = 2;
            rand_bytes($urandom_range(1, 40));
            run_load(2);
        end

        // Ignoring wait with a stalled memory must overflow the FIFO.
        ready_mode = 1;
        rand_bytes(0);
        begin_load();
        for (int k = 0; k < 4 * DEPTH; k++) send_raw(k, 8'($urandom));
        check("ovf_full", dut.r_count_q, DEPTH);
        check("ovf_flag", dut.r_overflow_q, 1);
        check("ovf_wait", ioctl_wait, 1);
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("ovf_rst_flag", dut.r_overflow_q, 0);

        // Reset mid-load, then a fresh two-byte load.
        ready_mode = 2;
        rand_bytes(5);
        begin_load();
        for (int k = 0; k < 5; k++) send_byte(k, fbytes[k]);
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        tick();
        check("mrst_we", mem_we, 0);
        check("mrst_wait", ioctl_wait, 0);
        check("mrst_loading", loading, 0);
        check("mrst_fifo", dut.r_count_q, 0);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (5) begin
            tick();
            if (load_done) pulses++;
        end
        check("mrst_no_done", pulses, 0);
        ready_mode = 0;
        rand_bytes(2);
        run_load(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
